// File: rtl/pe_pkg.sv
// Shared definitions for the PE command issuer.
// Holds the PE opcode and function codes, the bit positions of the opcode
// and function fields inside the PE's opcode_func word, the issuer FSM
// state encoding, and a helper that packs an opcode_func word.
package pe_pkg;

  localparam logic [6:0] OPC_ARITH = 7'b0000001;
  localparam logic [6:0] OPC_FPU   = 7'b0000010;
  localparam logic [6:0] OPC_COMP  = 7'b0010000;

  localparam logic [4:0] FN_ADD  = 5'b00001;
  localparam logic [4:0] FN_SUB  = 5'b00010;
  localparam logic [4:0] FN_MAC  = 5'b00011;
  localparam logic [4:0] FN_FMAX = 5'b00100;
  localparam logic [4:0] FN_FMIN = 5'b00101;
  localparam logic [4:0] FN_EQ   = 5'b01000;
  localparam logic [4:0] FN_LT   = 5'b01001;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 25;
  localparam int FUNC_HI = 24;
  localparam int FUNC_LO = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [31:0] pack_opfunc(input logic [6:0] opc, input logic [4:0] fn);
    logic [31:0] w;
    w = '0;
    w[OPC_HI:OPC_LO]   = opc;
    w[FUNC_HI:FUNC_LO] = fn;
    return w;
  endfunction

endpackage

// File: rtl/pe_issue_ctrl_fifo.sv
// Response FIFO for the PE issuer: first-word-fall-through, no bypass.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears storage too)
//   push, wdata write one entry
//   pop         remove the head entry (ignored when empty)
//   rdata       head entry, valid while empty=0
//   empty       no entries held
//   count       number of entries held (0..DEPTH)
// A push and a pop on the same edge while full is legal: the slot being
// freed is the one being written, and the count is unchanged.
module pe_rsp_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/pe_issue_ctrl.sv
// Command issuer and result collector for one pe_core_v2 instance.
// Tagged commands are packed into the PE's opcode_func word and issued one
// per cycle; a shift register of {valid, tag} follows each command through
// the PE's fixed latency so the returning result can be re-tagged and queued
// in the response FIFO. The PE cannot stall, so a command is only accepted
// while FIFO entries plus commands in flight leave room in the FIFO.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   en                         1 = accept commands, 0 = drain
//   cmd_*                      command valid/ready, opcode, func, operands, tag
//   pe_opcode_func, pe_op1..3  registered command to the PE, held between issues
//   pe_valid_in                one-cycle issue strobe
//   pe_result_out/_valid       PE result and its strobe
//   rsp_valid/ready/data/tag   response stream, in issue order
//   busy                       work pending (FSM active, in flight, or FIFO non-empty)
//   err_spurious, err_missing  sticky PE protocol errors
//   issue_cnt, done_cnt        accepted / queued counts, wrapping
module pe_issue_ctrl
  import pe_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int PE_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_opcode,
  input  logic [4:0]       cmd_func,
  input  logic [31:0]      cmd_op1,
  input  logic [31:0]      cmd_op2,
  input  logic [31:0]      cmd_op3,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      pe_opcode_func,
  output logic [31:0]      pe_op1,
  output logic [31:0]      pe_op2,
  output logic [31:0]      pe_op3,
  output logic             pe_valid_in,
  input  logic [31:0]      pe_result_out,
  input  logic             pe_result_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             err_spurious,
  output logic             err_missing,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int FW = 32 + TAG_W;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  logic [FW-1:0]    fifo_rdata;
  logic             accept, fifo_push, fifo_pop, miss, retire;

  logic [PE_LAT:0]  vld_pipe;
  logic [TAG_W-1:0] tag_pipe [PE_LAT+1];

  // Credit check: every command in flight owns a future FIFO slot.
  assign cmd_ready = (state == RUN) && (({1'b0, fifo_count} + {1'b0, inflight}) < DEPTH_W);
  assign accept    = cmd_valid && cmd_ready;

  // The last pipeline stage lines up with pe_result_valid.
  assign fifo_push = vld_pipe[PE_LAT] && pe_result_valid;
  assign miss      = vld_pipe[PE_LAT] && !pe_result_valid;
  assign retire    = fifo_push || miss;
  assign fifo_pop  = rsp_valid && rsp_ready;

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = fifo_rdata[FW-1:TAG_W];
  assign rsp_tag   = fifo_rdata[TAG_W-1:0];
  assign busy      = (state != IDLE) || (inflight != '0) || !fifo_empty;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = DRAIN;
      DRAIN: begin
        if (en)                  state_nxt = RUN;
        else if (inflight == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      inflight     <= '0;
      issue_cnt    <= '0;
      done_cnt     <= '0;
      err_spurious <= 1'b0;
      err_missing  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight + CW'(accept) - CW'(retire);
      if (accept)                               issue_cnt    <= issue_cnt + 1'b1;
      if (fifo_push)                            done_cnt     <= done_cnt + 1'b1;
      if (miss)                                 err_missing  <= 1'b1;
      if (pe_result_valid && !vld_pipe[PE_LAT]) err_spurious <= 1'b1;
    end
  end

  // Issue stage: command registered toward the PE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_valid_in    <= 1'b0;
      pe_opcode_func <= '0;
      pe_op1         <= '0;
      pe_op2         <= '0;
      pe_op3         <= '0;
    end else begin
      pe_valid_in <= accept;
      if (accept) begin
        pe_opcode_func <= pack_opfunc(cmd_opcode, cmd_func);
        pe_op1         <= cmd_op1;
        pe_op2         <= cmd_op2;
        pe_op3         <= cmd_op3;
      end
    end
  end

  // Expect pipeline: stage 0 is loaded alongside pe_valid_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i <= PE_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[PE_LAT-1:0], accept};
      tag_pipe[0] <= cmd_tag;
      for (int i = 1; i <= PE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  pe_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata ({pe_result_out, tag_pipe[PE_LAT]}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_pe_issue_ctrl.sv
// Bench for pe_issue_ctrl: a behavioural PE sits on the pe_* side, stimulus
// pushes each accepted command's expected {result, tag} into a queue, and an
// independent monitor pops and compares on every response handshake.
module tb_pe_issue_ctrl;
  import pe_pkg::*;

  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int PE_LAT = 2;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n, en, cmd_valid, cmd_ready;
  logic [6:0]       cmd_opcode;
  logic [4:0]       cmd_func;
  logic [31:0]      cmd_op1, cmd_op2, cmd_op3;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      pe_opcode_func, pe_op1, pe_op2, pe_op3;
  logic             pe_valid_in;
  logic [31:0]      pe_result_out;
  logic             pe_result_valid;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy, err_spurious, err_missing;
  logic [CNT_W-1:0] issue_cnt, done_cnt;

  logic pe_drop   = 1'b0;
  logic pe_inject = 1'b0;
  bit   rnd_mode  = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_issue = 0;
  int n_done  = 0;
  logic [32+TAG_W-1:0] exp_q [$];

  always #5 clk = ~clk;

  pe_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PE_LAT(PE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_func(cmd_func),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_op3(cmd_op3), .cmd_tag(cmd_tag),
    .pe_opcode_func(pe_opcode_func), .pe_op1(pe_op1), .pe_op2(pe_op2), .pe_op3(pe_op3),
    .pe_valid_in(pe_valid_in), .pe_result_out(pe_result_out), .pe_result_valid(pe_result_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .busy(busy), .err_spurious(err_spurious), .err_missing(err_missing),
    .issue_cnt(issue_cnt), .done_cnt(done_cnt)
  );

  // Reference PE behaviour, also used for randomized expected values.
  function automatic logic [31:0] pe_ref(input logic [6:0] opc, input logic [4:0] fn,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
    case (opc)
      OPC_ARITH: case (fn)
        FN_ADD:  return a + b;
        FN_SUB:  return a - b;
        FN_MAC:  return a * b + c;
        default: return 32'd0;
      endcase
      OPC_FPU: case (fn)
        FN_FMAX: return ($signed(a) > $signed(b)) ? a : b;
        FN_FMIN: return ($signed(a) < $signed(b)) ? a : b;
        default: return 32'd0;
      endcase
      OPC_COMP: case (fn)
        FN_EQ:   return {31'd0, a == b};
        FN_LT:   return {31'd0, $signed(a) < $signed(b)};
        default: return 32'd0;
      endcase
      default: return 32'd666666;
    endcase
  endfunction

  // Behavioural PE: fixed latency, no reset, optional drop / inject.
  logic [PE_LAT-1:0] pm_vld = '0;
  logic [31:0]       pm_res [PE_LAT];
  always @(posedge clk) begin
    pm_vld[0] <= pe_valid_in;
    pm_res[0] <= pe_ref(pe_opcode_func[OPC_HI:OPC_LO], pe_opcode_func[FUNC_HI:FUNC_LO],
                        pe_op1, pe_op2, pe_op3);
    for (int i = 1; i < PE_LAT; i++) begin
      pm_vld[i] <= pm_vld[i-1];
      pm_res[i] <= pm_res[i-1];
    end
  end
  assign pe_result_valid = (pm_vld[PE_LAT-1] && !pe_drop) || pe_inject;
  assign pe_result_out   = pm_res[PE_LAT-1];

  // Response monitor.
  always @(negedge clk) begin
    logic [32+TAG_W-1:0] e;
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected got data=%0h tag=%0h required none", rsp_data, rsp_tag);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_data, rsp_tag} !== e) begin
          n_bad++;
          $display("FAIL rsp_data_tag got data=%0h tag=%0h required data=%0h tag=%0h",
                   rsp_data, rsp_tag, e[32+TAG_W-1:TAG_W], e[TAG_W-1:0]);
        end
      end
    end
    if (rst_n === 1'b1 && dut.fifo_push && !dut.fifo_pop && int'(dut.fifo_count) == DEPTH) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fifo_overflow got push while full required no push");
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h required=%0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [6:0] opc, input logic [4:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [TAG_W-1:0] tag, input bit want, input logic [31:0] exp_d,
                      input int max_wait, output bit acc);
    bit r;
    cmd_opcode = opc; cmd_func = fn;
    cmd_op1 = a; cmd_op2 = b; cmd_op3 = c; cmd_tag = tag;
    cmd_valid = 1'b1;
    acc = 1'b0;
    for (int w = 0; w < max_wait && !acc; w++) begin
      @(negedge clk);
      r = cmd_ready;
      tick();
      if (r) acc = 1'b1;
    end
    cmd_valid = 1'b0;
    if (acc) begin
      n_issue++;
      if (want) begin
        exp_q.push_back({exp_d, tag});
        n_done++;
      end
    end
  endtask

  task automatic wait_empty(input int max_c);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_c) begin
      tick();
      n++;
    end
    check("drain_queue_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic zero_outputs(input string p);
    check({p, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
    check({p, "_pe_valid_in"}, 64'(pe_valid_in), 64'd0);
    check({p, "_pe_opcode_func"}, 64'(pe_opcode_func), 64'd0);
    check({p, "_pe_ops"}, 64'(pe_op1 | pe_op2 | pe_op3), 64'd0);
    check({p, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({p, "_rsp_data_tag"}, 64'({rsp_data, rsp_tag}), 64'd0);
    check({p, "_busy"}, 64'(busy), 64'd0);
    check({p, "_errs"}, 64'({err_spurious, err_missing}), 64'd0);
    check({p, "_cnts"}, 64'({issue_cnt, done_cnt}), 64'd0);
  endtask

  // ADD 5+3 tag 7 with an empty FIFO: issue word, one-cycle strobe, k+3 response.
  task automatic add_scenario(input string p);
    bit acc;
    rsp_ready = 1'b1;
    send(OPC_ARITH, FN_ADD, 32'd5, 32'd3, 32'd0, 4'd7, 1'b1, 32'd8, 20, acc);
    check({p, "_accepted"}, 64'(acc), 64'd1);
    @(negedge clk);
    check({p, "_opfunc"}, 64'(pe_opcode_func), 64'h0210_0000);
    check({p, "_valid_in_hi"}, 64'(pe_valid_in), 64'd1);
    check({p, "_op1"}, 64'(pe_op1), 64'd5);
    @(negedge clk);
    check({p, "_valid_in_lo"}, 64'(pe_valid_in), 64'd0);
    check({p, "_opfunc_hold"}, 64'(pe_opcode_func), 64'h0210_0000);
    @(negedge clk);
    check({p, "_rsp_early"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    check({p, "_rsp_k3"}, 64'({rsp_valid, rsp_data, rsp_tag}), 64'({1'b1, 32'd8, 4'd7}));
    tick();
  endtask

  initial begin
    bit acc, acc5;
    int acc_total;
    logic [CNT_W-1:0] bi, bd;
    logic [6:0] opcs [5];
    logic [4:0] fns [8];
    logic [6:0] o;
    logic [4:0] f;
    logic [31:0] a, b, c;

    opcs = '{OPC_ARITH, OPC_FPU, OPC_COMP, 7'h7F, 7'h00};
    fns  = '{FN_ADD, FN_SUB, FN_MAC, FN_FMAX, FN_FMIN, FN_EQ, FN_LT, 5'h1F};

    rst_n = 1'b0; en = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opcode = '0; cmd_func = '0; cmd_op1 = '0; cmd_op2 = '0; cmd_op3 = '0; cmd_tag = '0;
    ticks(3);
    zero_outputs("reset");
    rst_n = 1'b1;
    ticks(2);
    en = 1'b1;
    add_scenario("add");

    // Backpressure: FIFO blocked, credit limits accepts to DEPTH.
    bi = issue_cnt; bd = done_cnt;
    rsp_ready = 1'b0;
    acc_total = 0;
    for (int i = 0; i < 4; i++) begin
      send(OPC_ARITH, FN_SUB, 32'd10, 32'(i), 32'd0, 4'(i), 1'b1, 32'(10 - i), 1, acc);
      acc_total += int'(acc);
    end
    send(OPC_ARITH, FN_SUB, 32'd10, 32'd4, 32'd0, 4'd4, 1'b1, 32'd6, 8, acc5);
    acc_total += int'(acc5);
    check("bp_accepted", 64'(acc_total), 64'd4);
    @(negedge clk);
    check("bp_ready_low", 64'(cmd_ready), 64'd0);
    rsp_ready = 1'b1;
    for (int i = (acc5 ? 5 : 4); i < 8; i++)
      send(OPC_ARITH, FN_SUB, 32'd10, 32'(i), 32'd0, 4'(i), 1'b1, 32'(10 - i), 30, acc);
    wait_empty(200);
    ticks(2);
    check("bp_issue_delta", 64'(CNT_W'(issue_cnt - bi)), 64'd8);
    check("bp_done_delta", 64'(CNT_W'(done_cnt - bd)), 64'd8);
    check("bp_no_errors", 64'({err_spurious, err_missing}), 64'd0);

    // Drain: three commands, then en low.
    for (int i = 0; i < 3; i++)
      send(OPC_ARITH, FN_ADD, 32'(100 * i), 32'd1, 32'd0, 4'(9 + i), 1'b1, 32'(100 * i + 1), 20, acc);
    en = 1'b0;
    tick();
    @(negedge clk);
    check("drain_ready_low", 64'(cmd_ready), 64'd0);
    check("drain_busy", 64'(busy), 64'd1);
    wait_empty(50);
    check("drain_idle_busy", 64'(busy), 64'd0);

    // Spurious PE result while idle.
    tick();
    pe_inject = 1'b1;
    tick();
    pe_inject = 1'b0;
    ticks(2);
    check("spurious_set", 64'({err_spurious, err_missing}), 64'b10);
    ticks(5);
    check("spurious_sticky", 64'(err_spurious), 64'd1);

    // Dropped PE result.
    en = 1'b1;
    pe_drop = 1'b1;
    send(OPC_ARITH, FN_ADD, 32'd1, 32'd1, 32'd0, 4'd2, 1'b0, 32'd0, 20, acc);
    ticks(6);
    pe_drop = 1'b0;
    check("missing_set", 64'(err_missing), 64'd1);
    en = 1'b0;
    ticks(4);
    check("missing_busy_clear", 64'({busy, rsp_valid}), 64'd0);

    // Unknown opcode and FPU MAX, in order.
    en = 1'b1;
    send(7'h7F, 5'd0, 32'd1, 32'd2, 32'd3, 4'd3, 1'b1, 32'd666666, 20, acc);
    send(OPC_FPU, FN_FMAX, 32'd4, 32'd9, 32'd0, 4'd4, 1'b1, 32'd9, 20, acc);
    wait_empty(50);

    // Randomized traffic with random downstream stalls.
    bi = issue_cnt; bd = done_cnt;
    rnd_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ticks($urandom_range(0, 2));
      o = opcs[$urandom_range(0, 4)];
      f = fns[$urandom_range(0, 7)];
      a = $urandom; b = $urandom; c = $urandom;
      if ($urandom_range(0, 1) == 1) begin a = a % 16; b = b % 16; end
      send(o, f, a, b, c, 4'($urandom), 1'b1, pe_ref(o, f, a, b, c), 60, acc);
    end
    rnd_mode = 1'b0;
    rsp_ready = 1'b1;
    wait_empty(500);
    ticks(2);
    check("rnd_issue_delta", 64'(CNT_W'(issue_cnt - bi)), 64'd60);
    check("rnd_done_delta", 64'(CNT_W'(done_cnt - bd)), 64'd60);

    // Asynchronous reset with two in flight and two queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(OPC_ARITH, FN_ADD, 32'(i), 32'd20, 32'd0, 4'(i + 1), 1'b1, 32'(i + 20), 1, acc);
    tick();
    #1 rst_n = 1'b0;
    #1 zero_outputs("midrst");
    exp_q.delete();
    n_issue = 0;
    n_done = 0;
    #1 rst_n = 1'b1;
    ticks(5);
    check("post_rst_spurious", 64'(err_spurious), 64'd1);
    check("post_rst_empty", 64'({rsp_valid, issue_cnt, done_cnt}), 64'd0);
    ticks(2);
    add_scenario("post_rst_add");
    wait_empty(20);
    check("final_counts", 64'({issue_cnt, done_cnt}), 64'({CNT_W'(n_issue), CNT_W'(n_done)}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_issue_ctrl.md
Name: pe_issue_ctrl

Overview:
Command issuer and result collector that drives one pe_core_v2 instance.
- Accepts tagged commands over a valid/ready interface and packs them into the PE's opcode_func word.
- Issues commands to the PE and tracks them through its fixed-latency pipeline. The PE has no backpressure, so issue is credit-limited.
- Queues each PE result with its tag in a response FIFO and presents it downstream over valid/ready.

Parameters:
DEPTH, 4, response FIFO entries; power of two, >= 2
TAG_W, 4, command/response tag width
PE_LAT, 2, PE latency in cycles from valid_in to result_valid
CNT_W, 16, width of the issue and completion counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = accept commands; 0 = drain
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_opcode  in  7  PE opcode (0000001 ARITH, 0000010 FPU, 0010000 COMP)
cmd_func  in  5  PE function code
cmd_op1, cmd_op2, cmd_op3  in  32 each  operands
cmd_tag  in  TAG_W  tag, returned with the response
pe_opcode_func  out  32  {opcode, func, 20'd0}
pe_op1, pe_op2, pe_op3  out  32 each  operands to PE
pe_valid_in  out  1  PE issue strobe
pe_result_out  in  32  PE result
pe_result_valid  in  1  PE result strobe
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_data  out  32  result
rsp_tag  out  TAG_W  tag of the command that produced rsp_data
busy  out  1  state != IDLE or inflight != 0 or FIFO non-empty
err_spurious  out  1  sticky: pe_result_valid arrived with no expected result
err_missing  out  1  sticky: expected result did not arrive
issue_cnt, done_cnt  out  CNT_W each  accepted / written-to-FIFO counts; wrap modulo 2^CNT_W

Behaviour:
- Reset: state IDLE. The following are 0: all outputs, the FIFO, pointers, counters, error flags and the tag pipeline. Reset asserted mid-operation discards everything in flight; a result arriving after reset release is flagged err_spurious.
- FSM states and transitions:
  - IDLE -> RUN when en=1.
  - RUN -> DRAIN when en=0.
  - DRAIN -> IDLE when inflight=0. Entries already in the FIFO are still delivered in DRAIN and in IDLE.
  - DRAIN -> RUN when en=1 again.
- cmd_ready = (state==RUN) && (fifo_count + inflight < DEPTH). It is combinational from registered state only and does not depend on cmd_valid.
- Accept: cmd_valid && cmd_ready at edge k. The pe_* outputs and pe_valid_in=1 are registered from this edge and appear in the cycle after it; pe_valid_in is high for exactly one cycle per accepted command. Back-to-back accepts give a continuous pe_valid_in. When nothing is issued, pe_op* and pe_opcode_func hold their last values.
- inflight counts commands that are accepted but not yet written to the FIFO; max PE_LAT+1.
  - +1 on accept, -1 on FIFO write.
  - Simultaneous accept and write leaves it unchanged.
- Tag/expect pipeline: a PE_LAT+1 stage shift register of {valid, tag}, advanced every cycle and aligned with pe_result_valid.
- At each cycle:
  - expected=1, pe_result_valid=1: write {pe_result_out, tag} to the FIFO; done_cnt++.
  - expected=1, pe_result_valid=0: set err_missing; inflight--; no write.
  - expected=0, pe_result_valid=1: set err_spurious; data is dropped.
- Latency with an empty FIFO: rsp_valid=1 three cycles after the accept edge (edge k+3), carrying the matching rsp_tag.
- FIFO:
  - No bypass; first-word-fall-through outputs (rsp_data/rsp_tag valid while rsp_valid=1).
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop when full is legal; the count is unchanged.
  - Overflow is impossible by construction of the credit check. The verifier checks this with an assertion (push while full = bug).
- Ordering: responses are returned strictly in issue order.
- Error flags clear only on reset.

Decomposition:
- Package pe_pkg holds:
  - opcode localparams (OPC_ARITH, OPC_FPU, OPC_COMP) and the func codes;
  - the opcode_func field positions [31:25] and [24:20];
  - FSM state encoding (IDLE, RUN, DRAIN).
- One sub-module, pe_rsp_fifo: a parameterised FIFO of width 32+TAG_W and depth DEPTH, with count output.

Test Plan:
- en=1; ADD (opcode 0000001, func 00001) with op1=5, op2=3, tag=7, rsp_ready=1 -> pe_opcode_func=32'h02100000 for one cycle; rsp_valid=1, rsp_data=8, rsp_tag=7 at accept edge+3.
- rsp_ready=0; 8 back-to-back commands (SUB 10-i, tags 0..7) -> exactly 4 accepted, then cmd_ready=0. Raise rsp_ready -> all 8 responses are delivered in tag order; issue_cnt=done_cnt=8; no errors.
- Three commands issued, then en=0 the next cycle -> state DRAIN, cmd_ready=0. All 3 responses delivered; state IDLE once inflight=0; busy=0 after the final pop.
- PE model drives pe_result_valid with no issue -> err_spurious=1 and sticky. A dropped PE result -> err_missing=1; inflight returns to 0; busy eventually 0.
- Opcode 1111111 and FPU MAX(op1=4, op2=9) -> rsp_data 666666 and 9 respectively, in order.
- rst_n pulsed low with 2 commands in flight and 2 in the FIFO -> all outputs 0 immediately (asynchronous). The stale PE result after release sets err_spurious; the next command behaves as in the first scenario.
